axis_frame_classifier: RTL and testbench

// Sink-side counterpart of the fake 64-bit AXI-Stream frame source: accepts Ethernet frames
// (first wire byte in tdata[7:0]), parses the L2/L3 header on the fly and emits one result

---
 rtl/axis_frame_classifier.sv | 217 +++++++++++++++++++++
 tb/tb_axis_frame_classifier.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_frame_classifier.sv
// Parses L2/L3 headers of 64-bit AXI-Stream Ethernet frames on the fly; one registered result per frame
// one cycle after the tlast beat. Input stalls (tready=0) while a result is held unconsumed.
module axis_frame_classifier #(
    parameter logic [47:0] LOCAL_MAC = 48'h211abcdef112,
    parameter int          MAX_BEATS = 190,
    parameter int          CNT_W     = 16
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_rx_axis_tvalid,
    input  logic [63:0]      i_rx_axis_tdata,
    input  logic [7:0]       i_rx_axis_tkeep,
    input  logic             i_rx_axis_tlast,
    output logic             o_rx_axis_tready,
    output logic             o_res_valid,
    input  logic             i_res_ready,
    output logic [2:0]       o_res_type,
    output logic [10:0]      o_res_len,
    output logic             o_res_mac_match,
    output logic [2:0]       o_res_err,
    output logic [CNT_W-1:0] o_cnt_arp,
    output logic [CNT_W-1:0] o_cnt_icmp,
    output logic [CNT_W-1:0] o_cnt_udp,
    output logic [CNT_W-1:0] o_cnt_err
);

    localparam int            BW       = $clog2(MAX_BEATS + 1);
    localparam logic [BW-1:0] LAST_IDX = BW'(MAX_BEATS - 1);

    localparam logic [2:0] T_OTHER = 3'd0;
    localparam logic [2:0] T_ARP   = 3'd1;
    localparam logic [2:0] T_ICMP  = 3'd2;
    localparam logic [2:0] T_UDP   = 3'd3;
    localparam logic [2:0] T_IPV4  = 3'd4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_HDR,
        S_BODY,
        S_DROP
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [BW-1:0] beat_cnt;
    logic [47:0]   dst_mac_q;
    logic [15:0]   etype_q;
    logic [7:0]    proto_q;
    logic          bad_keep_q;

    logic          beat_acc;
    logic          last_acc;
    logic          hdr_b0;
    logic          hdr_b1;
    logic          hdr_b2;
    logic [47:0]   cur_mac;
    logic [15:0]   cur_etype;
    logic [47:0]   eff_mac;
    logic [15:0]   eff_etype;
    logic [7:0]    eff_proto;
    logic [3:0]    pop_cnt;
    logic [7:0]    keep_p1;
    logic          last_keep_ok;
    logic          beat_bad;
    logic          frame_bad;
    logic [31:0]   len_full;
    logic [10:0]   len_sat;
    logic [10:0]   len_nxt;
    logic [2:0]    type_nxt;
    logic [2:0]    err_nxt;
    logic          mac_nxt;
    logic          unused_tdata;

    assign o_rx_axis_tready = ~o_res_valid | i_res_ready;
    assign beat_acc         = i_rx_axis_tvalid & o_rx_axis_tready;
    assign last_acc         = beat_acc & i_rx_axis_tlast;
    assign unused_tdata     = ^i_rx_axis_tdata[55:48];

    // Header beats are only meaningful before the frame is being discarded.
    assign hdr_b0 = (state != S_DROP) && (beat_cnt == BW'(0));
    assign hdr_b1 = (state != S_DROP) && (beat_cnt == BW'(1));
    assign hdr_b2 = (state != S_DROP) && (beat_cnt == BW'(2));

    assign cur_mac   = {i_rx_axis_tdata[7:0],   i_rx_axis_tdata[15:8],  i_rx_axis_tdata[23:16],
                        i_rx_axis_tdata[31:24], i_rx_axis_tdata[39:32], i_rx_axis_tdata[47:40]};
    assign cur_etype = {i_rx_axis_tdata[39:32], i_rx_axis_tdata[47:40]};

    // Bypass the current beat so a frame ending on a header beat still classifies correctly.
    assign eff_mac   = hdr_b0 ? cur_mac : dst_mac_q;
    assign eff_etype = hdr_b1 ? cur_etype : etype_q;
    assign eff_proto = hdr_b2 ? i_rx_axis_tdata[63:56] : proto_q;

    always_comb begin
        pop_cnt = 4'd0;
        for (int i = 0; i < 8; i++) begin
            pop_cnt = pop_cnt + {3'b000, i_rx_axis_tkeep[i]};
        end
    end

    assign keep_p1      = i_rx_axis_tkeep + 8'd1;
    assign last_keep_ok = (i_rx_axis_tkeep != 8'h00) && ((i_rx_axis_tkeep & keep_p1) == 8'h00);
    assign beat_bad     = i_rx_axis_tlast ? ~last_keep_ok : (i_rx_axis_tkeep != 8'hFF);
    assign frame_bad    = bad_keep_q | beat_bad;

    assign len_full = (32'(beat_cnt) << 3) + 32'(pop_cnt);
    assign len_sat  = (len_full[31:11] != 21'd0) ? 11'h7FF : len_full[10:0];

    always_comb begin
        type_nxt = T_OTHER;
        if (beat_cnt != BW'(0)) begin
            if (eff_etype == 16'h0806) begin
                type_nxt = T_ARP;
            end else if (eff_etype == 16'h0800 && beat_cnt >= BW'(2)) begin
                case (eff_proto)
                    8'h01:   type_nxt = T_ICMP;
                    8'h11:   type_nxt = T_UDP;
                    default: type_nxt = T_IPV4;
                endcase
            end
        end
    end

    always_comb begin
        mac_nxt = (eff_mac == LOCAL_MAC) || (eff_mac == 48'hFFFF_FFFF_FFFF);
        if (state == S_DROP) begin
            len_nxt = 11'h7FF;
            err_nxt = {1'b1, frame_bad, 1'b0};
        end else begin
            len_nxt = len_sat;
            err_nxt = {1'b0, frame_bad, (len_sat < 11'd42)};
        end
    end

    always_comb begin
        state_nxt = state;
        if (beat_acc) begin
            if (i_rx_axis_tlast) begin
                state_nxt = S_IDLE;
            end else if (state != S_DROP && beat_cnt == LAST_IDX) begin
                state_nxt = S_DROP;
            end else begin
                case (state)
                    S_IDLE:  state_nxt = S_HDR;
                    S_HDR:   state_nxt = (beat_cnt == BW'(2)) ? S_BODY : S_HDR;
                    default: state_nxt = state;
                endcase
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state      <= S_IDLE;
            beat_cnt   <= '0;
            dst_mac_q  <= '0;
            etype_q    <= '0;
            proto_q    <= '0;
            bad_keep_q <= 1'b0;
        end else begin
            state <= state_nxt;
            if (beat_acc) begin
                if (i_rx_axis_tlast) begin
                    beat_cnt   <= '0;
                    bad_keep_q <= 1'b0;
                end else begin
                    bad_keep_q <= frame_bad;
                    if (state != S_DROP) begin
                        beat_cnt <= beat_cnt + BW'(1);
                    end
                end
                if (hdr_b0) dst_mac_q <= cur_mac;
                if (hdr_b1) etype_q   <= cur_etype;
                if (hdr_b2) proto_q   <= i_rx_axis_tdata[63:56];
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_res_valid     <= 1'b0;
            o_res_type      <= T_OTHER;
            o_res_len       <= '0;
            o_res_mac_match <= 1'b0;
            o_res_err       <= '0;
        end else if (last_acc) begin
            o_res_valid     <= 1'b1;
            o_res_type      <= type_nxt;
            o_res_len       <= len_nxt;
            o_res_mac_match <= mac_nxt;
            o_res_err       <= err_nxt;
        end else if (i_res_ready) begin
            o_res_valid <= 1'b0;
        end
    end

    // Errored frames go only to the error counter; all counters stick at full scale.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_cnt_arp  <= '0;
            o_cnt_icmp <= '0;
            o_cnt_udp  <= '0;
            o_cnt_err  <= '0;
        end else if (last_acc) begin
            if (err_nxt != 3'b000) begin
                if (o_cnt_err != '1) o_cnt_err <= o_cnt_err + CNT_W'(1);
            end else begin
                case (type_nxt)
                    T_ARP:   if (o_cnt_arp  != '1) o_cnt_arp  <= o_cnt_arp  + CNT_W'(1);
                    T_ICMP:  if (o_cnt_icmp != '1) o_cnt_icmp <= o_cnt_icmp + CNT_W'(1);
                    T_UDP:   if (o_cnt_udp  != '1) o_cnt_udp  <= o_cnt_udp  + CNT_W'(1);
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_axis_frame_classifier.sv
// Directed bench: frames built byte-wise, expected records derived from whole-frame rules, checked every cycle.
module tb_axis_frame_classifier;

    localparam int          MAXB = 190;
    localparam logic [47:0] LMAC = 48'h211abcdef112;
    localparam logic [47:0] BMAC = 48'hFFFF_FFFF_FFFF;
    localparam logic [47:0] XMAC = 48'h0a0b0c0d0e0f;

    logic        i_clk = 1'b0;
    logic        i_reset = 1'b0;
    logic        tvalid = 1'b0;
    logic [63:0] tdata = '0;
    logic [7:0]  tkeep = '0;
    logic        tlast = 1'b0;
    logic        res_ready = 1'b1;

    logic        tready, res_valid, mac;
    logic [2:0]  rtype, err;
    logic [10:0] rlen;
    logic [15:0] c_arp, c_icmp, c_udp, c_err;

    logic        tready2, res_valid2, mac2;
    logic [2:0]  rtype2, err2;
    logic [10:0] rlen2;
    logic [1:0]  c2_arp, c2_icmp, c2_udp, c2_err;

    always #5 i_clk = ~i_clk;

    axis_frame_classifier dut (
        .i_clk(i_clk), .i_reset(i_reset),
        .i_rx_axis_tvalid(tvalid), .i_rx_axis_tdata(tdata), .i_rx_axis_tkeep(tkeep),
        .i_rx_axis_tlast(tlast), .o_rx_axis_tready(tready),
        .o_res_valid(res_valid), .i_res_ready(res_ready),
        .o_res_type(rtype), .o_res_len(rlen), .o_res_mac_match(mac), .o_res_err(err),
        .o_cnt_arp(c_arp), .o_cnt_icmp(c_icmp), .o_cnt_udp(c_udp), .o_cnt_err(c_err)
    );

    axis_frame_classifier #(.CNT_W(2)) dut2 (
        .i_clk(i_clk), .i_reset(i_reset),
        .i_rx_axis_tvalid(tvalid), .i_rx_axis_tdata(tdata), .i_rx_axis_tkeep(tkeep),
        .i_rx_axis_tlast(tlast), .o_rx_axis_tready(tready2),
        .o_res_valid(res_valid2), .i_res_ready(res_ready),
        .o_res_type(rtype2), .o_res_len(rlen2), .o_res_mac_match(mac2), .o_res_err(err2),
        .o_cnt_arp(c2_arp), .o_cnt_icmp(c2_icmp), .o_cnt_udp(c2_udp), .o_cnt_err(c2_err)
    );

    typedef struct {
        int typ;
        int len;
        int mac;
        int err;
    } exp_t;

    logic [7:0]  fb    [0:2047];
    logic [63:0] bdat  [0:255];
    logic [7:0]  bkeep [0:255];
    int          nb;

    exp_t q[$];
    exp_t ce;
    exp_t pe;
    int   ra = 0, ri = 0, ru = 0, re = 0;
    int   n_chk = 0, n_pass = 0;
    bit   run_chk = 1'b0;
    bit   watch_b2b = 1'b0;
    bit   b2b_low = 1'b0;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
    endtask

    function automatic int sat(input int v, input int m);
        return (v > m) ? m : v;
    endfunction

    task automatic build(input logic [47:0] dst, input logic [15:0] et, input logic [7:0] pr,
                         input int nbytes, input bit ovr, input logic [7:0] ovr_keep);
        int rem;
        for (int i = 0; i < 2048; i++) fb[i] = (i < nbytes) ? 8'(i * 7 + 3) : 8'h00;
        for (int k = 0; k < 6; k++) fb[k] = dst[47 - 8 * k -: 8];
        for (int k = 6; k < 12; k++) fb[k] = 8'(8'h40 + k);
        fb[12] = et[15:8];
        fb[13] = et[7:0];
        fb[23] = pr;
        nb = (nbytes + 7) / 8;
        for (int b = 0; b < nb; b++) begin
            for (int k = 0; k < 8; k++) bdat[b][8 * k +: 8] = fb[8 * b + k];
            bkeep[b] = 8'hFF;
        end
        rem = nbytes - 8 * (nb - 1);
        bkeep[nb - 1] = 8'((1 << rem) - 1);
        if (ovr) bkeep[nb - 1] = ovr_keep;
    endtask

    // Expected record from the whole frame as a byte string.
    function automatic exp_t model();
        exp_t        e;
        int          len;
        bit          bad;
        logic [47:0] m;
        logic [15:0] et;
        bad = 1'b0;
        for (int b = 0; b < nb; b++) begin
            if (b < nb - 1) bad |= (bkeep[b] != 8'hFF);
            else bad |= !(bkeep[b] inside {8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF});
        end
        m = {fb[0], fb[1], fb[2], fb[3], fb[4], fb[5]};
        e.mac = (m == LMAC || m == BMAC) ? 1 : 0;
        et = {fb[12], fb[13]};
        e.typ = 0;
        if (nb >= 2 && et == 16'h0806) e.typ = 1;
        else if (nb >= 3 && et == 16'h0800) e.typ = (fb[23] == 8'h01) ? 2 : (fb[23] == 8'h11) ? 3 : 4;
        if (nb > MAXB) begin
            e.len = 2047;
            e.err = 4 + (bad ? 2 : 0);
        end else begin
            len = 8 * (nb - 1) + $countones(bkeep[nb - 1]);
            e.len = (len > 2047) ? 2047 : len;
            e.err = (bad ? 2 : 0) + ((e.len < 42) ? 1 : 0);
        end
        return e;
    endfunction

    task automatic push();
        exp_t e;
        e = model();
        q.push_back(e);
        if (e.err != 0) re++;
        else if (e.typ == 1) ra++;
        else if (e.typ == 2) ri++;
        else if (e.typ == 3) ru++;
    endtask

    // Drive nbeats of the built frame (all when nbeats < 0); inputs change #1 after posedge.
    task automatic send(input int nbeats);
        int lim;
        int g;
        bit acc;
        lim = (nbeats < 0) ? nb : nbeats;
        for (int b = 0; b < lim; b++) begin
            tvalid = 1'b1;
            tdata  = bdat[b];
            tkeep  = bkeep[b];
            tlast  = (b == nb - 1);
            g = 0;
            forever begin
                @(negedge i_clk);
                acc = tready;
                @(posedge i_clk);
                #1;
                if (acc) break;
                g++;
                if (g > 2000) begin
                    chk("accept_timeout", 0, 1);
                    $display("%0d/%0d checks passed", n_pass, n_chk);
                    $fatal(1, "beat never accepted");
                end
            end
        end
        tvalid = 1'b0;
        tlast  = 1'b0;
        tdata  = '0;
        if (nbeats < 0) push();
    endtask

    task automatic drain();
        int g;
        g = 0;
        while (q.size() != 0 && g < 300) begin
            @(posedge i_clk);
            #1;
            g++;
        end
        chk("drain_queue_empty", q.size(), 0);
    endtask

    task automatic do_reset();
        i_reset = 1'b1;
        tvalid  = 1'b0;
        tlast   = 1'b0;
        q.delete();
        ra = 0; ri = 0; ru = 0; re = 0;
        repeat (2) @(posedge i_clk);
        #1;
        i_reset = 1'b0;
    endtask

    // Per-cycle comparison against the model queue and model counters.
    always @(negedge i_clk) begin
        if (run_chk) begin
            chk("res_valid", res_valid, q.size() != 0);
            chk("tready", tready, (q.size() == 0) || res_ready);
            chk("tready2", tready2, (q.size() == 0) || res_ready);
            if (watch_b2b && !tready) b2b_low = 1'b1;
            chk("cnt_arp", c_arp, sat(ra, 65535));
            chk("cnt_icmp", c_icmp, sat(ri, 65535));
            chk("cnt_udp", c_udp, sat(ru, 65535));
            chk("cnt_err", c_err, sat(re, 65535));
            chk("cnt2_arp", c2_arp, sat(ra, 3));
            chk("cnt2_icmp", c2_icmp, sat(ri, 3));
            chk("cnt2_udp", c2_udp, sat(ru, 3));
            chk("cnt2_err", c2_err, sat(re, 3));
            if (q.size() != 0) begin
                ce = q[0];
                chk("res_type", rtype, ce.typ);
                chk("res_len", rlen, ce.len);
                chk("res_mac", mac, ce.mac);
                chk("res_err", err, ce.err);
                chk("res2_type", rtype2, ce.typ);
                chk("res2_len", rlen2, ce.len);
                chk("res2_err", err2, ce.err);
                if (res_ready) void'(q.pop_front());
            end
        end
    end

    initial begin
        #1 i_reset = 1'b1;
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        chk("reset_valid", res_valid, 0);
        chk("reset_tready", tready, 1);
        chk("reset_cnt_arp", c_arp, 0);
        @(posedge i_clk);
        #1;
        i_reset = 1'b0;
        run_chk = 1'b1;

        // Local ARP, 42 bytes
        build(LMAC, 16'h0806, 8'h00, 42, 1'b0, 8'h00);
        pe = model();
        chk("pin_arp_type", pe.typ, 1);
        chk("pin_arp_len", pe.len, 42);
        chk("pin_arp_mac", pe.mac, 1);
        chk("pin_arp_err", pe.err, 0);
        chk("pin_arp_lastkeep", bkeep[5], 8'h03);
        send(-1);
        drain();
        chk("arp_cnt", c_arp, 1);

        // ICMP then UDP back-to-back, then two single-beat frames on consecutive cycles
        watch_b2b = 1'b1;
        build(LMAC, 16'h0800, 8'h01, 74, 1'b0, 8'h00);
        pe = model();
        chk("pin_icmp_len", pe.len, 74);
        send(-1);
        build(LMAC, 16'h0800, 8'h11, 74, 1'b0, 8'h00);
        send(-1);
        build(BMAC, 16'h0800, 8'h11, 6, 1'b0, 8'h00);
        pe = model();
        chk("pin_single_type", pe.typ, 0);
        chk("pin_single_err", pe.err, 1);
        chk("pin_single_len", pe.len, 6);
        send(-1);
        build(XMAC, 16'h0806, 8'h00, 5, 1'b0, 8'h00);
        send(-1);
        watch_b2b = 1'b0;
        drain();
        chk("b2b_tready_low", b2b_low, 0);
        chk("b2b_cnt_icmp", c_icmp, 1);
        chk("b2b_cnt_udp", c_udp, 1);

        // Held result stalls the next frame
        res_ready = 1'b0;
        build(LMAC, 16'h0800, 8'h01, 74, 1'b0, 8'h00);
        send(-1);
        build(XMAC, 16'h0800, 8'h11, 74, 1'b0, 8'h00);
        fork
            send(-1);
            begin
                repeat (4) @(negedge i_clk);
                chk("stall_tready", tready, 0);
                chk("stall_valid", res_valid, 1);
                chk("stall_type_held", rtype, 2);
                @(posedge i_clk);
                #1;
                res_ready = 1'b1;
            end
        join
        drain();

        // Bad last tkeep on a UDP frame
        build(LMAC, 16'h0800, 8'h11, 74, 1'b1, 8'h05);
        pe = model();
        chk("pin_badkeep_err", pe.err, 2);
        chk("pin_badkeep_len", pe.len, 74);
        send(-1);
        drain();
        chk("badkeep_cnt_udp", c_udp, 2);

        // Oversize 200-beat frame, short IPv4 runt, IPv4-other, broadcast ARP
        build(LMAC, 16'h0800, 8'h11, 1600, 1'b0, 8'h00);
        pe = model();
        chk("pin_over_len", pe.len, 2047);
        chk("pin_over_err", pe.err, 4);
        send(-1);
        build(LMAC, 16'h0800, 8'h01, 16, 1'b0, 8'h00);
        pe = model();
        chk("pin_runt_type", pe.typ, 0);
        chk("pin_runt_err", pe.err, 1);
        chk("pin_runt_len", pe.len, 16);
        send(-1);
        build(XMAC, 16'h0800, 8'h06, 64, 1'b0, 8'h00);
        pe = model();
        chk("pin_ipv4_type", pe.typ, 4);
        chk("pin_ipv4_mac", pe.mac, 0);
        send(-1);
        build(BMAC, 16'h0806, 8'h00, 60, 1'b0, 8'h00);
        send(-1);
        drain();
        chk("mid_cnt_err", c_err, 5);
        chk("mid_cnt2_err", c2_err, 3);
        chk("mid_cnt_arp", c_arp, 2);

        // Reset in the middle of an ICMP frame, then a full ARP
        build(LMAC, 16'h0800, 8'h01, 74, 1'b0, 8'h00);
        send(4);
        do_reset();
        build(LMAC, 16'h0806, 8'h00, 42, 1'b0, 8'h00);
        send(-1);
        drain();
        chk("rst_cnt_arp", c_arp, 1);
        chk("rst_cnt_icmp", c_icmp, 0);

        // Five more ARPs saturate the 2-bit counter
        for (int i = 0; i < 5; i++) send(-1);
        drain();
        chk("final_cnt_arp", c_arp, 6);
        chk("final_cnt2_arp", c2_arp, 3);

        repeat (3) @(posedge i_clk);
        run_chk = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
